sfx_scheduler: RTL and testbench

Schedules the single MP3 decoder channel between looping background music and four one-shot sound effects (jump, coin, stomp, die). Sits between the game logic and the `mp3` player, in the 2 MHz `clk_2` domain from `Divider`. Replaces the hard-wired `play = 1`. It latches effect requests, arbitrates by fixed priority with preemption, and inserts a silence gap before every track change. It drives track select and a start/ready handshake to the player.

---
 rtl/sfx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_sfx_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - single-channel mp3 scheduler: looping BGM plus four prioritised one-shot effects
module sfx_scheduler #(
    parameter int GAP_CYCLES  = 200,
    parameter int SFX_TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bgm_en,
    input  logic [3:0] sfx_req,
    input  logic       mp3_ready,
    input  logic       mp3_done,
    output logic [2:0] track,
    output logic       start,
    output logic       play,
    output logic       sfx_active,
    output logic       locked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_START,
        S_PLAY_BGM,
        S_PLAY_SFX,
        S_LOCKED
    } state_t;

    localparam logic [2:0]  TRK_DIE  = 3'd4;
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES);
    localparam logic [20:0] TO_LAST  = 21'(SFX_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [3:0]  pend, pend_nx, pend_upd;
    logic [2:0]  cur, cur_nx;
    logic [15:0] gap_cnt;
    logic [20:0] to_cnt;

    logic [3:0]  cur_bit, cur_low;
    logic [2:0]  sfx_tgt;
    logic [3:0]  tgt_bit;
    logic        has_tgt, higher, gap_done, timeout;

    // Masks for the current effect: its own request bit and every bit at or below it
    always_comb begin
        cur_bit = 4'b0000;
        cur_low = 4'b0000;
        case (cur)
            3'd1:    begin cur_bit = 4'b0001; cur_low = 4'b0001; end
            3'd2:    begin cur_bit = 4'b0010; cur_low = 4'b0011; end
            3'd3:    begin cur_bit = 4'b0100; cur_low = 4'b0111; end
            3'd4:    begin cur_bit = 4'b1000; cur_low = 4'b1111; end
            default: begin cur_bit = 4'b0000; cur_low = 4'b0000; end
        endcase
    end

    // Latch new requests; a re-request of the effect being started/played is dropped, nothing latches while locked
    always_comb begin
        pend_nx = pend | sfx_req;
        if (state == S_START || state == S_PLAY_SFX) begin
            pend_nx = pend | (sfx_req & ~cur_bit);
        end
        if (state == S_LOCKED) begin
            pend_nx = 4'b0000;
        end
    end

    // Fixed priority pick: die > stomp > coin > jump, BGM only as fallback
    always_comb begin
        sfx_tgt = 3'd0;
        tgt_bit = 4'b0000;
        if (pend_nx[3]) begin
            sfx_tgt = 3'd4;
            tgt_bit = 4'b1000;
        end else if (pend_nx[2]) begin
            sfx_tgt = 3'd3;
            tgt_bit = 4'b0100;
        end else if (pend_nx[1]) begin
            sfx_tgt = 3'd2;
            tgt_bit = 4'b0010;
        end else if (pend_nx[0]) begin
            sfx_tgt = 3'd1;
            tgt_bit = 4'b0001;
        end
        has_tgt  = (sfx_tgt != 3'd0) || bgm_en;
        higher   = |(pend_nx & ~cur_low);
        gap_done = (gap_cnt >= GAP_LAST);
        timeout  = (to_cnt >= TO_LAST);
    end

    // Next-state logic; the target is frozen into cur on START entry and its pending bit consumed
    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        pend_upd = pend_nx;
        case (state)
            S_IDLE: begin
                if (pend_nx != 4'b0000 || bgm_en) begin
                    state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    if (has_tgt) begin
                        state_nx = S_START;
                        cur_nx   = sfx_tgt;
                        pend_upd = pend_nx & ~tgt_bit;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_START: begin
                if (mp3_ready) begin
                    state_nx = (cur != 3'd0) ? S_PLAY_SFX : S_PLAY_BGM;
                end
            end
            S_PLAY_BGM: begin
                if (pend_nx != 4'b0000 || mp3_done || !bgm_en) begin
                    state_nx = S_GAP;
                end
            end
            S_PLAY_SFX: begin
                // Completion wins over a simultaneous higher request
                if (mp3_done || timeout) begin
                    if (cur == TRK_DIE) begin
                        state_nx = S_LOCKED;
                        pend_upd = 4'b0000;
                    end else begin
                        state_nx = S_GAP;
                    end
                end else if (higher) begin
                    state_nx = S_GAP;
                end
            end
            S_LOCKED: begin
                pend_upd = 4'b0000;
                if (!bgm_en) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; counters restart on every state change and saturate
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pend       <= 4'b0000;
            cur        <= 3'd0;
            gap_cnt    <= 16'd0;
            to_cnt     <= 21'd0;
            track      <= 3'd0;
            start      <= 1'b0;
            play       <= 1'b0;
            sfx_active <= 1'b0;
            locked     <= 1'b0;
        end else begin
            state <= state_nx;
            pend  <= pend_upd;
            cur   <= cur_nx;
            if (state_nx != state) begin
                gap_cnt <= 16'd0;
                to_cnt  <= 21'd0;
            end else begin
                if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
                if (to_cnt != 21'h1FFFFF) to_cnt <= to_cnt + 21'd1;
            end
            track      <= cur_nx;
            start      <= (state_nx == S_START);
            play       <= (state_nx == S_PLAY_BGM) || (state_nx == S_PLAY_SFX);
            sfx_active <= (state_nx == S_PLAY_SFX);
            locked     <= (state_nx == S_LOCKED);
        end
    end

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb/tb_sfx_scheduler.sv - directed scoreboard bench for sfx_scheduler
module tb_sfx_scheduler;

    logic       clk;
    logic       rst;
    logic       bgm_en;
    logic [3:0] sfx_req;
    logic       mp3_ready;
    logic       mp3_done;
    logic [2:0] track;
    logic       start;
    logic       play;
    logic       sfx_active;
    logic       locked;

    int tests  = 0;
    int failed = 0;
    logic [2:0] sb[$];

    sfx_scheduler #(
        .GAP_CYCLES (4),
        .SFX_TIMEOUT(50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bgm_en    (bgm_en),
        .sfx_req   (sfx_req),
        .mp3_ready (mp3_ready),
        .mp3_done  (mp3_done),
        .track     (track),
        .start     (start),
        .play      (play),
        .sfx_active(sfx_active),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input logic [3:0] v);
        sfx_req = v;
        step();
        sfx_req = 4'b0000;
    endtask

    task automatic pulse_done();
        mp3_done = 1'b1;
        step();
        mp3_done = 1'b0;
    endtask

    task automatic expect_start(input string tag);
        logic [2:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'd7;
        check({tag, "_start"}, start, 1);
        check({tag, "_track"}, track, exp);
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 60 && start !== 1'b1; i++) step();
        expect_start(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_track"}, track, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_play"}, play, 0);
        check({tag, "_sfx_active"}, sfx_active, 0);
        check({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int bad;
        int n;
        rst       = 1'b0;
        bgm_en    = 1'b0;
        sfx_req   = 4'b0000;
        mp3_ready = 1'b1;
        mp3_done  = 1'b0;
        step();
        step();
        step();
        check_all_zero("reset");

        // BGM loop: START five cycles after reset release
        bgm_en = 1'b1;
        rst    = 1'b1;
        sb.push_back(3'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (start !== 1'b0 || play !== 1'b0) bad++;
        end
        check("bgm_gap_quiet", bad, 0);
        step();
        expect_start("bgm_first");
        step();
        check("bgm_play", play, 1);
        check("bgm_no_start", start, 0);

        // Done during BGM: five silent cycles then restart of track 0
        sb.push_back(3'd0);
        mp3_done = 1'b1;
        step();
        mp3_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (play !== 1'b0 || start !== 1'b0) bad++;
            step();
        end
        check("loop_gap_quiet", bad, 0);
        expect_start("bgm_loop");
        step();
        check("bgm_loop_play", play, 1);

        // Coin preempts BGM, BGM resumes after it
        sb.push_back(3'd2);
        pulse_req(4'b0010);
        check("preempt_play_low", play, 0);
        wait_start("coin");
        step();
        check("coin_sfx_active", sfx_active, 1);
        check("coin_play", play, 1);
        sb.push_back(3'd0);
        pulse_done();
        wait_start("after_coin");
        step();
        check("after_coin_sfx_idle", sfx_active, 0);

        // Jump preempted by coin, second jump queued behind coin
        sb.push_back(3'd1);
        pulse_req(4'b0001);
        wait_start("jump");
        step();
        sb.push_back(3'd2);
        pulse_req(4'b0010);
        wait_start("coin_over_jump");
        step();
        sb.push_back(3'd1);
        pulse_req(4'b0001);
        check("queued_jump_no_preempt", sfx_active, 1);
        pulse_done();
        wait_start("queued_jump");
        step();
        sb.push_back(3'd0);
        pulse_done();
        wait_start("bgm_after_jump");
        step();

        // Same-cycle jump and stomp: stomp first
        sb.push_back(3'd3);
        sb.push_back(3'd1);
        pulse_req(4'b0101);
        wait_start("stomp_first");
        step();
        pulse_done();
        wait_start("jump_second");
        step();
        sb.push_back(3'd0);
        pulse_done();
        wait_start("bgm_after_pair");
        step();

        // Die completes into lock; requests ignored until bgm_en drops
        sb.push_back(3'd4);
        pulse_req(4'b1000);
        wait_start("die");
        step();
        check("die_active", sfx_active, 1);
        pulse_done();
        check("die_locked", locked, 1);
        check("die_play_low", play, 0);
        sfx_req = 4'hF;
        step();
        step();
        step();
        sfx_req = 4'h0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (start !== 1'b0 || play !== 1'b0) bad++;
            step();
        end
        check("locked_ignores_req", bad, 0);
        check("still_locked", locked, 1);
        bgm_en = 1'b0;
        step();
        check("unlock", locked, 0);
        check("unlock_play", play, 0);
        bgm_en = 1'b1;
        sb.push_back(3'd0);
        wait_start("bgm_after_unlock");
        step();

        // Handshake: start and track held while mp3_ready low
        mp3_ready = 1'b0;
        sb.push_back(3'd2);
        pulse_req(4'b0010);
        wait_start("hs_coin");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (start !== 1'b1 || track !== 3'd2 || play !== 1'b0) bad++;
        end
        check("hs_hold", bad, 0);
        mp3_ready = 1'b1;
        step();
        check("hs_play", play, 1);
        check("hs_start_drop", start, 0);

        // Timeout: effect lasts exactly 50 cycles without mp3_done
        n = 0;
        while (sfx_active === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check("timeout_len", n, 50);
        sb.push_back(3'd0);
        wait_start("bgm_after_timeout");
        step();

        // Reset mid-play with jump pending
        sb.push_back(3'd2);
        pulse_req(4'b0010);
        wait_start("coin_before_reset");
        step();
        pulse_req(4'b0001);
        rst    = 1'b0;
        bgm_en = 1'b0;
        step();
        check_all_zero("mid_reset");
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (start !== 1'b0 || play !== 1'b0) bad++;
        end
        check("no_jump_after_reset", bad, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
